spi_master_tx: RTL and testbench

SPI_MASTER_TX -- requirements
Module: spi_master_tx

---
 rtl/spi_master_tx.sv | 170 +++++++++++++++++
 tb/tb_spi_master_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit-only master: accepts one word, frames it with chip select,
// shifts it MSB first on sclk, then enforces a minimum cs-high guard time.
module spi_master_tx #(
  parameter int reg_width   = 8,
  parameter int half_period = 2,
  parameter int guard       = 2
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic [reg_width-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 cs,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state_o
);

  localparam int HCW = $clog2(half_period) + 1;
  localparam int BCW = $clog2(reg_width) + 1;
  localparam int GCW = $clog2(guard) + 1;

  localparam logic [HCW-1:0] HP_LAST  = HCW'(half_period - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(reg_width - 1);
  localparam logic [GCW-1:0] G_LAST   = GCW'(guard - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GUARD = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [HCW-1:0]         hp_cnt_q, hp_cnt_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]         g_cnt_q, g_cnt_d;
  logic [reg_width-1:0]   shreg_q, shreg_d;
  logic                   cs_q, cs_d;
  logic                   sclk_q, sclk_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic                   accept;

  // Handshake: a word transfers on a rising edge where tx_valid is high and the
  // block is idle, or on the edge that ends the guard time (the first edge the
  // block would otherwise spend idle), so a held tx_valid gives exactly guard
  // cycles of cs high between frames. tx_ready flags the idle state.
  always_comb begin
    state_d   = state_q;
    hp_cnt_d  = hp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    g_cnt_d   = g_cnt_q;
    shreg_d   = shreg_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    done_d    = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        accept = tx_valid;
      end
      LEAD: begin
        if (hp_cnt_q == HP_LAST) begin
          hp_cnt_d = '0;
          sclk_d   = 1'b1;
          state_d  = SHIFT;
        end else begin
          hp_cnt_d = hp_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (hp_cnt_q == HP_LAST) begin
          hp_cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            // The last falling edge leaves the final bit on mosi through TRAIL.
            if (bit_cnt_q == BIT_LAST) begin
              state_d = TRAIL;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shreg_d   = {shreg_q[reg_width-2:0], 1'b1};
            end
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 1'b1;
        end
      end
      TRAIL: begin
        if (hp_cnt_q == HP_LAST) begin
          hp_cnt_d = '0;
          g_cnt_d  = '0;
          cs_d     = 1'b1;
          shreg_d  = '1;
          done_d   = 1'b1;
          state_d  = GUARD;
        end else begin
          hp_cnt_d = hp_cnt_q + 1'b1;
        end
      end
      GUARD: begin
        if (g_cnt_q == G_LAST) begin
          g_cnt_d = '0;
          if (tx_valid) accept = 1'b1;
          else          state_d = IDLE;
        end else begin
          g_cnt_d = g_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d   = LEAD;
      shreg_d   = tx_data;
      cs_d      = 1'b0;
      sclk_d    = 1'b0;
      hp_cnt_d  = '0;
      bit_cnt_d = '0;
    end

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      hp_cnt_q  <= '0;
      bit_cnt_q <= '0;
      g_cnt_q   <= '0;
      shreg_q   <= '1;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      hp_cnt_q  <= hp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      g_cnt_q   <= g_cnt_d;
      shreg_q   <= shreg_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  // The shift register MSB is the mosi flop; it is all ones whenever cs is high.
  assign mosi        = shreg_q[reg_width-1];
  assign cs          = cs_q;
  assign sclk        = sclk_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign tx_ready    = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: default instance plus a half_period=1/guard=1 instance,
// each checked cycle by cycle against a frame-timing model and a serial receiver.
module tb_spi_master_tx;

  localparam int W    = 8;
  localparam int HP_A = 2;
  localparam int G_A  = 2;
  localparam int HP_B = 1;
  localparam int G_B  = 1;

  logic       clk;
  logic       rstn;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       ready_a, cs_a, sclk_a, mosi_a, busy_a, done_a;
  logic       ready_b, cs_b, sclk_b, mosi_b, busy_b, done_b;
  logic [2:0] dbg_a, dbg_b;
  logic [5:0] obs_a, obs_b;

  int tests = 0;
  int fails = 0;
  int done_cnt_a = 0;

  int         rx_n_a, rx_n_b;
  logic [7:0] rx_sh_a, rx_sh_b;
  int         rx_cnt_a_q[$], rx_cnt_b_q[$];
  logic [7:0] rx_byte_a_q[$], rx_byte_b_q[$];

  spi_master_tx #(.reg_width(W), .half_period(HP_A), .guard(G_A)) u_dut_a (
    .sys_clk(clk), .rstn(rstn), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(ready_a), .cs(cs_a), .sclk(sclk_a), .mosi(mosi_a),
    .busy(busy_a), .done(done_a), .dbg_state_o(dbg_a)
  );

  spi_master_tx #(.reg_width(W), .half_period(HP_B), .guard(G_B)) u_dut_b (
    .sys_clk(clk), .rstn(rstn), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(ready_b), .cs(cs_b), .sclk(sclk_b), .mosi(mosi_b),
    .busy(busy_b), .done(done_b), .dbg_state_o(dbg_b)
  );

  assign obs_a = {cs_a, sclk_a, mosi_a, done_a, busy_a, ready_a};
  assign obs_b = {cs_b, sclk_b, mosi_b, done_b, busy_b, ready_b};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done_a === 1'b1) done_cnt_a++;

  // serial receivers: sample mosi on sclk rising edges while cs is low
  always @(negedge cs_a) rx_n_a = 0;
  always @(posedge sclk_a) if (cs_a === 1'b0) begin rx_sh_a = {rx_sh_a[6:0], mosi_a}; rx_n_a++; end
  always @(posedge cs_a) if (rstn === 1'b1) begin rx_cnt_a_q.push_back(rx_n_a); rx_byte_a_q.push_back(rx_sh_a); end

  always @(negedge cs_b) rx_n_b = 0;
  always @(posedge sclk_b) if (cs_b === 1'b0) begin rx_sh_b = {rx_sh_b[6:0], mosi_b}; rx_n_b++; end
  always @(posedge cs_b) if (rstn === 1'b1) begin rx_cnt_b_q.push_back(rx_n_b); rx_byte_b_q.push_back(rx_sh_b); end

  // reference: outputs {cs,sclk,mosi,done,busy,tx_ready} n cycles after acceptance
  function automatic logic [5:0] model(input int n, input int hp, input int g, input logic [7:0] d);
    int m, low;
    logic c, s, mo, dn, b;
    m   = n / hp;
    low = (2 * W + 1) * hp;
    c   = (n >= low);
    s   = (m % 2 == 1) && (m < 2 * W);
    if (n >= low)        mo = 1'b1;
    else if (m >= 2 * W) mo = d[0];
    else                 mo = d[7 - m / 2];
    dn  = (n == low);
    b   = (n < low + g);
    return {c, s, mo, dn, b, !b};
  endfunction

  function automatic int frame_len(input bit fast);
    return fast ? (2 * W + 1) * HP_B + G_B : (2 * W + 1) * HP_A + G_A;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called #1 after the acceptance edge; checks offsets 0..ncyc-1 and ends at offset ncyc.
  task automatic check_frame(input bit fast, input logic [7:0] d, input int ncyc,
                             input bit noise, input string tag, output int hi);
    logic [5:0] o, e;
    int hp, g;
    hp = fast ? HP_B : HP_A;
    g  = fast ? G_B : G_A;
    hi = 0;
    for (int n = 0; n < ncyc; n++) begin
      o = fast ? obs_b : obs_a;
      e = model(n, hp, g, d);
      tests++;
      assert (o === e) else begin
        fails++;
        $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, o, e);
      end
      if (o[5] === 1'b1) hi++;
      if (noise && !fast) begin
        if (n >= HP_A && n < 2 * W * HP_A - 1) begin
          tx_valid_a = 1'($urandom_range(0, 1));
          tx_data_a  = 8'($urandom);
        end else begin
          tx_valid_a = 1'b0;
        end
      end
      step();
    end
  endtask

  task automatic check_rx(input bit fast, input logic [7:0] d, input string tag);
    int c;
    logic [7:0] b;
    if (fast ? (rx_cnt_b_q.size() == 0) : (rx_cnt_a_q.size() == 0)) begin
      tests++;
      fails++;
      $error("FAIL %s_rx observed=no_frame expected=%h", tag, d);
    end else begin
      if (fast) begin c = rx_cnt_b_q.pop_front(); b = rx_byte_b_q.pop_front(); end
      else      begin c = rx_cnt_a_q.pop_front(); b = rx_byte_a_q.pop_front(); end
      check({tag, "_rx"}, {c[3:0], b}, {4'd8, d});
    end
  endtask

  task automatic send(input bit fast, input logic [7:0] d, input bit noise, input string tag);
    int hi;
    if (fast) begin tx_data_b = d; tx_valid_b = 1'b1; end
    else      begin tx_data_a = d; tx_valid_a = 1'b1; end
    step();
    if (fast) begin tx_valid_b = 1'b0; tx_data_b = 8'($urandom); end
    else      begin tx_valid_a = 1'b0; tx_data_a = 8'($urandom); end
    check_frame(fast, d, frame_len(fast) + 1, noise, tag, hi);
    check_rx(fast, d, tag);
  endtask

  // scoreboard of random bytes sent to the default instance
  logic [7:0] exp_q[$];

  initial begin
    int hi, done_before;
    logic [7:0] d;
    rstn = 1'b1;
    tx_data_a = '0; tx_valid_a = 1'b0;
    tx_data_b = '0; tx_valid_b = 1'b0;
    rx_n_a = 0; rx_n_b = 0; rx_sh_a = '0; rx_sh_b = '0;

    #1 rstn = 1'b0;
    #1;
    check("reset_a", {6'd0, obs_a}, {6'd0, 6'b101001});
    check("reset_b", {6'd0, obs_b}, {6'd0, 6'b101001});
    step();
    step();
    rstn = 1'b1;
    step();
    step();
    check("idle_a", {6'd0, obs_a}, {6'd0, 6'b101001});

    // single frame 0xA5
    done_before = done_cnt_a;
    send(1'b0, 8'hA5, 1'b0, "a5");
    check("a5_done_cnt", 12'(done_cnt_a - done_before), 12'd1);

    // back-to-back 0x3C then 0xC3 with tx_valid held
    tx_data_a = 8'h3C; tx_valid_a = 1'b1;
    step();
    tx_data_a = 8'hC3;
    check_frame(1'b0, 8'h3C, frame_len(1'b0), 1'b0, "b2b_3c", hi);
    check("b2b_gap", 12'(hi), 12'(G_A));
    tx_valid_a = 1'b0; tx_data_a = 8'($urandom);
    check_frame(1'b0, 8'hC3, frame_len(1'b0) + 1, 1'b0, "b2b_c3", hi);
    check_rx(1'b0, 8'h3C, "b2b_3c");
    check_rx(1'b0, 8'hC3, "b2b_c3");

    // tx_valid and tx_data toggled during SHIFT
    send(1'b0, 8'h81, 1'b1, "noise_81");

    // reset after the third sclk rise of 0xFF
    done_before = done_cnt_a;
    tx_data_a = 8'hFF; tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    check_frame(1'b0, 8'hFF, 5 * HP_A + 1, 1'b0, "abort_ff", hi);
    #2 rstn = 1'b0;
    #1;
    check("abort_async", {6'd0, obs_a}, {6'd0, 6'b101001});
    step();
    step();
    step();
    rstn = 1'b1;
    step();
    check("abort_no_frame", 12'(rx_cnt_a_q.size()), 12'd0);
    check("abort_no_done", 12'(done_cnt_a - done_before), 12'd0);
    send(1'b0, 8'h00, 1'b0, "after_abort_00");
    check("after_abort_done", 12'(done_cnt_a - done_before), 12'd1);

    // half_period=1, guard=1 instance
    send(1'b1, 8'h5A, 1'b0, "fast_5a");
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 2)) step();
      send(1'b1, d, 1'b0, "fast_rand");
    end

    // random frames on the default instance
    for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom));
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      repeat ($urandom_range(0, 3)) step();
      send(1'b0, d, 1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
